// File: rtl/config_chain_loader_if.sv
// Host word-load and start port of the configuration chain loader.
interface config_chain_loader_if #(
    parameter int WORD_W = 16
);
    logic              load_valid;
    logic [WORD_W-1:0] load_data;
    logic              load_ready;
    logic              flush;
    logic              start;

    modport master (
        output load_valid, load_data, flush, start,
        input  load_ready
    );

    modport slave (
        input  load_valid, load_data, flush, start,
        output load_ready
    );
endinterface

// File: rtl/config_chain_loader.sv
// Serial writer for the PIRDSP configuration scan chain, MSB of the image first.
// CFG_CHAIN_VERIFY_EN adds a second pass that checks bits returning on the tail.
module config_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    config_chain_loader_if.slave  host,
    output logic                  cfg_in,
    output logic                  cfg_en,
    input  logic                  cfg_return,
    output logic                  busy,
    output logic                  done,
    output logic                  mismatch
);
    localparam int N_WORDS = CHAIN_LEN / WORD_W;
    localparam int IDX_W   = $clog2(CHAIN_LEN);
    localparam int CNT_W   = $clog2(N_WORDS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(N_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
`ifdef CFG_CHAIN_VERIFY_EN
        VERIFY,
`endif
        DONE
    } state_t;

    state_t               state;
    logic [CHAIN_LEN-1:0] image;
    logic [CNT_W-1:0]     count;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     idx_dec;

    assign idx_dec         = idx - IDX_W'(1);
    assign host.load_ready = (state == IDLE) && (count < FULL);

`ifndef CFG_CHAIN_VERIFY_EN
    logic unused_return;
    assign unused_return = cfg_return;
    assign mismatch      = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            image  <= '0;
            count  <= '0;
            idx    <= '0;
            cfg_in <= 1'b0;
            cfg_en <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef CFG_CHAIN_VERIFY_EN
            mismatch <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (host.flush) begin
                        count <= '0;
                    end else if (host.start && count == FULL) begin
                        state  <= SHIFT;
                        idx    <= LAST_IDX;
                        cfg_in <= image[LAST_IDX];
                        cfg_en <= 1'b1;
                        busy   <= 1'b1;
`ifdef CFG_CHAIN_VERIFY_EN
                        mismatch <= 1'b0;
`endif
                    end else if (host.load_valid && host.load_ready) begin
                        image[int'(count)*WORD_W +: WORD_W] <= host.load_data;
                        count <= count + CNT_W'(1);
                    end
                end
                SHIFT: begin
                    if (idx == '0) begin
`ifdef CFG_CHAIN_VERIFY_EN
                        // Re-drive the image so the chain ends holding it again.
                        state  <= VERIFY;
                        idx    <= LAST_IDX;
                        cfg_in <= image[LAST_IDX];
`else
                        state  <= DONE;
                        cfg_in <= 1'b0;
                        cfg_en <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
`endif
                    end else begin
                        idx    <= idx_dec;
                        cfg_in <= image[idx_dec];
                    end
                end
`ifdef CFG_CHAIN_VERIFY_EN
                VERIFY: begin
                    if (cfg_return != image[idx]) begin
                        mismatch <= 1'b1;
                    end
                    if (idx == '0) begin
                        state  <= DONE;
                        cfg_in <= 1'b0;
                        cfg_en <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        idx    <= idx_dec;
                        cfg_in <= image[idx_dec];
                    end
                end
`endif
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/config_chain_loader.md
# config_chain_loader

Serial writer for the configuration scan chain that runs through the PIRDSP blocks, e.g. the XORSIMD bit of the wide XOR block and its neighbours. A host fills an internal image buffer through a valid/ready word port and pulses `start`. The loader then drives `configuration_input`/`configuration_enable` into the head of the chain for exactly `CHAIN_LEN` cycles. With verification compiled in, it shifts the image a second time and checks the bits returning on the chain tail (`configuration_output` of the last element).

## Interface
- `CHAIN_LEN`, 64: total configuration bits in the chain; must be a multiple of `WORD_W`.
- `WORD_W`, 16: host word width; `N_WORDS = CHAIN_LEN/WORD_W`.

- `clk` in 1: single clock; all state on posedge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `load_valid` in 1: host word valid.
- `load_data` in WORD_W: image word; word i holds image bits [i*WORD_W+WORD_W-1 : i*WORD_W].
- `load_ready` out 1: word accepted when `load_valid && load_ready` at posedge.
- `flush` in 1: discards buffered words (count := 0) when in IDLE.
- `start` in 1: one-cycle request to shift the buffered image.
- `cfg_in` out 1: drives `configuration_input` of chain element 0.
- `cfg_en` out 1: drives `configuration_enable` of every chain element.
- `cfg_return` in 1: `configuration_output` of chain element CHAIN_LEN-1.
- `busy` out 1: high in SHIFT and VERIFY.
- `done` out 1: one-cycle pulse at end of operation.
- `mismatch` out 1: sticky verify failure; 0 when verification is compiled out.

## Operation
- Chain element k (k=0 nearest loader) must hold image bit k after SHIFT. Bits go out MSB first: image bit CHAIN_LEN-1 in the first enabled cycle, bit 0 in the last.
- States: IDLE, SHIFT, VERIFY (only with macro), DONE.
- IDLE:
  - `load_ready` = (count < N_WORDS); each accepted word is written to slot `count`, and `count` increments.
  - `flush` takes priority over a same-cycle load; the word is dropped.
  - `start` is honoured only when count == N_WORDS; otherwise it is ignored and no `done` is produced.
  - On an accepted start, the bit index is set to CHAIN_LEN-1 and the FSM goes to SHIFT.
- SHIFT:
  - `cfg_en`=1; `cfg_in` = image[index]; index decrements each cycle.
  - After CHAIN_LEN cycles the FSM goes to VERIFY if enabled, else DONE.
- VERIFY:
  - Same drive sequence for CHAIN_LEN cycles, so the chain ends holding the image again.
  - Each cycle with `cfg_en`=1, `cfg_return` is compared to the bit being driven, image[index]. Any inequality sets `mismatch`.
- DONE: `done`=1 for one cycle, then IDLE.
- Buffer contents and count are retained after DONE, so a second `start` re-shifts the same image without reloading.
- `mismatch` clears on the next accepted `start`.
- `start`, `load_valid` and `flush` are ignored while busy; `load_ready`=0 while busy.

## Timing
- Reset values: `load_ready`=1, `cfg_in`=0, `cfg_en`=0, `busy`=0, `done`=0, `mismatch`=0, count=0, state IDLE.
- `cfg_in`, `cfg_en`, `busy`, `done` and `mismatch` are registered outputs.
- Start is sampled at edge E. `cfg_en`=1 and `busy`=1 during cycles E+1 … E+CHAIN_LEN.
  - With VERIFY, this extends contiguously to E+2·CHAIN_LEN with no gap.
- `done` is high in cycle E+CHAIN_LEN+1, or E+2·CHAIN_LEN+1 with VERIFY; `busy` is 0 in that cycle.
- A start accepted in the same cycle the last word is loaded is ignored, because count is not yet N_WORDS.
- Reset mid-operation: `cfg_en` drops immediately (asynchronously) and the buffer is emptied. Chain contents are then undefined, and the host must reload and restart.

## Configuration
- `CFG_CHAIN_VERIFY_EN` defined: VERIFY state, tail comparison and `mismatch` logic are compiled in; the operation takes 2·CHAIN_LEN enabled cycles.
- `CFG_CHAIN_VERIFY_EN` undefined: VERIFY and comparison logic are absent; SHIFT goes straight to DONE; `cfg_return` is unused; `mismatch` is tied to 0.

## Test plan
All cases use defaults (CHAIN_LEN=64, WORD_W=16) and a 64-flop behavioural chain model.
- Load words 0x0001, 0x8000, 0xA5A5, 0xFFFF, then start:
  - `cfg_en` is high for exactly 64 cycles; element k equals image bit k (element 0=1, element 31=1, elements 48..63=1).
  - `done` pulses once at E+65 (macro off) or E+129 (macro on).
- Macro on, correct chain: after the same image, `mismatch`=0 and the chain still holds the image after VERIFY.
- Macro on, chain model with element 20 stuck-at-0 and image bit 20 = 1: `mismatch`=1 at `done` and stays 1 until the next start.
- Load 3 words only, pulse start: no `cfg_en`, no `done`. Load the 4th word, then `load_ready`=0; start now proceeds.
- Back-pressure and flush:
  - `load_valid` held for 6 cycles: only 4 words are accepted.
  - `flush` in IDLE, then `load_ready`=1; start before reload is ignored.
- `reset` asserted at cycle E+30 of SHIFT: `cfg_en`, `busy` and `done` go to 0 asynchronously, `load_ready`=1, and a subsequent start is ignored until 4 words are reloaded.
